// File: rtl/spi_bus_arbiter_if.sv
// Requester and spi_controller signal bundle shared by spi_bus_arbiter and its users.
// The slave modport is the arbiter's view; master is the view of whoever drives requests.
interface spi_bus_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int CMD_W  = 16,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]       iREQ;
  logic [N_REQ-1:0]       iREQ_LOCK;
  logic [N_REQ*CMD_W-1:0] iREQ_CMD;
  logic [N_REQ-1:0]       oGNT;
  logic [N_REQ-1:0]       oDONE;
  logic [N_REQ-1:0]       oERR;
  logic [DATA_W-1:0]      oRDATA;
  logic                   oBUSY;
  logic [CMD_W-1:0]       oP2S_DATA;
  logic                   oSPI_GO;
  logic                   iSPI_END;
  logic [DATA_W-1:0]      iS2P_DATA;

  modport slave (
    input  iREQ, iREQ_LOCK, iREQ_CMD, iSPI_END, iS2P_DATA,
    output oGNT, oDONE, oERR, oRDATA, oBUSY, oP2S_DATA, oSPI_GO
  );

  modport master (
    output iREQ, iREQ_LOCK, iREQ_CMD, iSPI_END, iS2P_DATA,
    input  oGNT, oDONE, oERR, oRDATA, oBUSY, oP2S_DATA, oSPI_GO
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one spi_controller port between N_REQ requesters,
// with lockable back-to-back grants and a watchdog on stuck transactions.
module spi_bus_arbiter #(
  parameter int N_REQ   = 3,
  parameter int CMD_W   = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic             iSPI_CLK,
  input  logic             iRST,
  spi_bus_arbiter_if.slave bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t            state_r, state_nx_s;
  logic [PTR_W-1:0]  ptr_r, ptr_nx_s;
  logic [PTR_W-1:0]  owner_r, owner_nx_s;
  logic [PTR_W-1:0]  win_idx_s;
  logic              win_found_s;
  logic [CMD_W-1:0]  win_cmd_s, own_cmd_s;
  logic [CMD_W-1:0]  cmd_r, cmd_nx_s;
  logic [N_REQ-1:0]  gnt_r, gnt_nx_s;
  logic [N_REQ-1:0]  done_r, done_nx_s;
  logic [N_REQ-1:0]  err_r, err_nx_s;
  logic [DATA_W-1:0] rdata_r, rdata_nx_s;
  logic              go_r, go_nx_s;
  logic              busy_r, busy_nx_s;
  logic [WD_W-1:0]   wd_r, wd_nx_s;
  logic              own_hold_s;
  logic [PTR_W-1:0]  ptr_after_s;

  function automatic logic [N_REQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
    to_onehot = ONE_HOT0 << idx;
  endfunction

  // First requesting index at or after ptr_r, wrapping modulo N_REQ.
  always_comb begin
    logic [PTR_W-1:0] idx_v;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    idx_v       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_v = PTR_W'((int'(ptr_r) + k) % N_REQ);
      if (!win_found_s && bus.iREQ[idx_v]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_v;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign win_cmd_s   = bus.iREQ_CMD[CMD_W*win_idx_s +: CMD_W];
  assign own_cmd_s   = bus.iREQ_CMD[CMD_W*owner_r +: CMD_W];
  assign own_hold_s  = bus.iREQ_LOCK[owner_r] & bus.iREQ[owner_r];
  assign ptr_after_s = (owner_r == LAST_IDX) ? '0 : owner_r + PTR_W'(1);

  // Next-state and next-output logic; done/err default low so they pulse one cycle.
  always_comb begin
    state_nx_s = state_r;
    ptr_nx_s   = ptr_r;
    owner_nx_s = owner_r;
    cmd_nx_s   = cmd_r;
    gnt_nx_s   = gnt_r;
    done_nx_s  = '0;
    err_nx_s   = '0;
    rdata_nx_s = rdata_r;
    go_nx_s    = go_r;
    wd_nx_s    = wd_r;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          owner_nx_s = win_idx_s;
          cmd_nx_s   = win_cmd_s;
          gnt_nx_s   = to_onehot(win_idx_s);
          go_nx_s    = 1'b1;
          wd_nx_s    = '0;
          state_nx_s = ST_XFER;
        end else begin
          gnt_nx_s = '0;
          go_nx_s  = 1'b0;
        end
      end
      ST_XFER: begin
        // End takes priority over a watchdog expiry in the same cycle.
        if (bus.iSPI_END) begin
          go_nx_s    = 1'b0;
          done_nx_s  = gnt_r;
          rdata_nx_s = bus.iS2P_DATA;
          state_nx_s = ST_RELEASE;
        end else if (wd_r == WD_LAST) begin
          go_nx_s    = 1'b0;
          err_nx_s   = gnt_r;
          state_nx_s = ST_RELEASE;
        end else begin
          wd_nx_s = wd_r + WD_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!bus.iSPI_END) begin
          if (own_hold_s) begin
            cmd_nx_s   = own_cmd_s;
            go_nx_s    = 1'b1;
            wd_nx_s    = '0;
            state_nx_s = ST_XFER;
          end else begin
            gnt_nx_s   = '0;
            ptr_nx_s   = ptr_after_s;
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_RELEASE;
        end
      end
      default: begin
        gnt_nx_s   = '0;
        go_nx_s    = 1'b0;
        state_nx_s = ST_IDLE;
      end
    endcase
    busy_nx_s = (state_nx_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iSPI_CLK) begin
    if (iRST) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      owner_r <= '0;
      cmd_r   <= '0;
      gnt_r   <= '0;
      done_r  <= '0;
      err_r   <= '0;
      rdata_r <= '0;
      go_r    <= 1'b0;
      busy_r  <= 1'b0;
      wd_r    <= '0;
    end else begin
      state_r <= state_nx_s;
      ptr_r   <= ptr_nx_s;
      owner_r <= owner_nx_s;
      cmd_r   <= cmd_nx_s;
      gnt_r   <= gnt_nx_s;
      done_r  <= done_nx_s;
      err_r   <= err_nx_s;
      rdata_r <= rdata_nx_s;
      go_r    <= go_nx_s;
      busy_r  <= busy_nx_s;
      wd_r    <= wd_nx_s;
    end
  end

  assign bus.oGNT      = gnt_r;
  assign bus.oDONE     = done_r;
  assign bus.oERR      = err_r;
  assign bus.oRDATA    = rdata_r;
  assign bus.oBUSY     = busy_r;
  assign bus.oP2S_DATA = cmd_r;
  assign bus.oSPI_GO   = go_r;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: a transaction table for arbitration order plus
// hand-written lock, mid-transaction, reset and watchdog sequences.
module tb_spi_bus_arbiter;
  localparam int N_REQ  = 3;
  localparam int CMD_W  = 16;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spi_bus_arbiter_if #(.N_REQ(N_REQ), .CMD_W(CMD_W), .DATA_W(DATA_W)) a ();
  spi_bus_arbiter_if #(.N_REQ(N_REQ), .CMD_W(CMD_W), .DATA_W(DATA_W)) b ();

  spi_bus_arbiter #(.N_REQ(N_REQ), .CMD_W(CMD_W), .DATA_W(DATA_W), .TIMEOUT(4096)) u_dut (
    .iSPI_CLK (clk),
    .iRST     (rst),
    .bus      (a.slave)
  );

  spi_bus_arbiter #(.N_REQ(N_REQ), .CMD_W(CMD_W), .DATA_W(DATA_W), .TIMEOUT(16)) u_dut_to (
    .iSPI_CLK (clk),
    .iRST     (rst),
    .bus      (b.slave)
  );

  typedef struct {
    logic [2:0]  req;
    int          dly;
    logic [7:0]  s2p;
    logic [2:0]  exp_gnt;
    logic [15:0] exp_cmd;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One unlocked transaction on DUT a, called at a negedge while it is idle.
  task automatic xfer_a(input logic [2:0] req, input int dly, input logic [7:0] s2p,
                        input logic [2:0] exp_gnt, input logic [15:0] exp_cmd);
    int gocnt;
    a.iREQ = req;
    @(negedge clk);
    chk("grant", a.oGNT, exp_gnt);
    chk("p2s_data", a.oP2S_DATA, exp_cmd);
    chk("busy", a.oBUSY, 1);
    gocnt = (a.oSPI_GO === 1'b1) ? 1 : 0;
    repeat (dly - 1) begin
      @(negedge clk);
      gocnt += (a.oSPI_GO === 1'b1) ? 1 : 0;
    end
    a.iSPI_END  = 1'b1;
    a.iS2P_DATA = s2p;
    @(negedge clk);
    chk("go_cycles", gocnt, dly);
    chk("go_low", a.oSPI_GO, 0);
    chk("done", a.oDONE, exp_gnt);
    chk("err_idle", a.oERR, 0);
    chk("rdata", a.oRDATA, s2p);
    a.iSPI_END = 1'b0;
    @(negedge clk);
    chk("grant_clear", a.oGNT, 0);
    chk("done_pulse", a.oDONE, 0);
    chk("busy_idle", a.oBUSY, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    int gocnt;
    int n;
    vt[0]  = '{3'b001, 20, 8'h5A, 3'b001, 16'h2D08};
    vt[1]  = '{3'b100, 3,  8'h11, 3'b100, 16'h8F00};
    vt[2]  = '{3'b111, 2,  8'h22, 3'b001, 16'h2D08};
    vt[3]  = '{3'b111, 1,  8'h33, 3'b010, 16'hB200};
    vt[4]  = '{3'b111, 4,  8'h44, 3'b100, 16'h8F00};
    vt[5]  = '{3'b111, 2,  8'h55, 3'b001, 16'h2D08};
    vt[6]  = '{3'b111, 3,  8'h66, 3'b010, 16'hB200};
    vt[7]  = '{3'b111, 1,  8'h77, 3'b100, 16'h8F00};
    vt[8]  = '{3'b110, 2,  8'h88, 3'b010, 16'hB200};
    vt[9]  = '{3'b011, 2,  8'h99, 3'b001, 16'h2D08};
    vt[10] = '{3'b101, 2,  8'hAA, 3'b100, 16'h8F00};
    vt[11] = '{3'b001, 1,  8'hBB, 3'b001, 16'h2D08};

    rst         = 1'b1;
    a.iREQ      = 3'b000;
    a.iREQ_LOCK = 3'b000;
    a.iREQ_CMD  = {16'h8F00, 16'hB200, 16'h2D08};
    a.iSPI_END  = 1'b0;
    a.iS2P_DATA = 8'h00;
    b.iREQ      = 3'b000;
    b.iREQ_LOCK = 3'b000;
    b.iREQ_CMD  = {16'h8F00, 16'hB200, 16'h2D08};
    b.iSPI_END  = 1'b0;
    b.iS2P_DATA = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_gnt", a.oGNT, 0);
    chk("rst_go", a.oSPI_GO, 0);
    chk("rst_busy", a.oBUSY, 0);
    chk("rst_p2s", a.oP2S_DATA, 0);
    chk("rst_rdata", a.oRDATA, 0);
    chk("rst_done_err", {a.oDONE, a.oERR}, 0);
    rst = 1'b0;

    // Arbitration order table; pointer evolves from row to row.
    for (int i = 0; i < 12; i++) begin
      xfer_a(vt[i].req, vt[i].dly, vt[i].s2p, vt[i].exp_gnt, vt[i].exp_cmd);
    end

    // Locked pair from requester 1 (ptr is 1 here), then requester 2, then 0.
    a.iREQ      = 3'b111;
    a.iREQ_LOCK = 3'b010;
    @(negedge clk);
    chk("lock_gnt1", a.oGNT, 3'b010);
    chk("lock_p2s1", a.oP2S_DATA, 16'hB200);
    repeat (2) @(negedge clk);
    a.iSPI_END  = 1'b1;
    a.iS2P_DATA = 8'hE1;
    @(negedge clk);
    chk("lock_done1", a.oDONE, 3'b010);
    chk("lock_rdata1", a.oRDATA, 8'hE1);
    a.iSPI_END = 1'b0;
    a.iREQ_CMD[CMD_W*1 +: CMD_W] = 16'hB300;
    @(negedge clk);
    chk("lock_hold_gnt", a.oGNT, 3'b010);
    chk("lock_go2", a.oSPI_GO, 1);
    chk("lock_p2s2", a.oP2S_DATA, 16'hB300);
    chk("lock_busy", a.oBUSY, 1);
    a.iSPI_END  = 1'b1;
    a.iS2P_DATA = 8'hE2;
    @(negedge clk);
    chk("lock_done2", a.oDONE, 3'b010);
    chk("lock_rdata2", a.oRDATA, 8'hE2);
    a.iSPI_END  = 1'b0;
    a.iREQ_LOCK = 3'b000;
    @(negedge clk);
    chk("lock_release", a.oGNT, 0);
    @(negedge clk);
    chk("after_lock_gnt", a.oGNT, 3'b100);
    chk("after_lock_p2s", a.oP2S_DATA, 16'h8F00);
    a.iSPI_END  = 1'b1;
    a.iS2P_DATA = 8'hE3;
    @(negedge clk);
    chk("req2_done", a.oDONE, 3'b100);
    a.iSPI_END = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("req0_gnt", a.oGNT, 3'b001);

    // Command change mid-transaction must not reach the SPI engine.
    a.iREQ_CMD[CMD_W*0 +: CMD_W] = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("frozen_cmd", a.oP2S_DATA, 16'h2D08);
    a.iSPI_END  = 1'b1;
    a.iS2P_DATA = 8'hE4;
    @(negedge clk);
    chk("req0_done", a.oDONE, 3'b001);
    a.iSPI_END = 1'b0;
    a.iREQ     = 3'b010;
    a.iREQ_CMD[CMD_W*0 +: CMD_W] = 16'h2D08;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_gnt", a.oGNT, 3'b010);

    // Reset mid-transfer clears everything including the pointer.
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    a.iREQ = 3'b111;
    @(negedge clk);
    chk("mrst_gnt", a.oGNT, 0);
    chk("mrst_go", a.oSPI_GO, 0);
    chk("mrst_busy", a.oBUSY, 0);
    chk("mrst_done_err", {a.oDONE, a.oERR}, 0);
    chk("mrst_rdata", a.oRDATA, 0);
    chk("mrst_p2s", a.oP2S_DATA, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_ptr_gnt", a.oGNT, 3'b001);
    a.iSPI_END = 1'b1;
    @(negedge clk);
    a.iSPI_END = 1'b0;
    a.iREQ     = 3'b000;
    @(negedge clk);

    // Watchdog instance: normal transfer first so rdata has a known value.
    b.iREQ = 3'b001;
    @(negedge clk);
    chk("to_gnt0", b.oGNT, 3'b001);
    b.iSPI_END  = 1'b1;
    b.iS2P_DATA = 8'hC3;
    @(negedge clk);
    chk("to_done0", b.oDONE, 3'b001);
    chk("to_rdata0", b.oRDATA, 8'hC3);
    b.iSPI_END = 1'b0;
    b.iREQ     = 3'b011;
    @(negedge clk);
    @(negedge clk);
    chk("to_gnt1", b.oGNT, 3'b010);
    gocnt = 0;
    n     = 0;
    while (b.oSPI_GO === 1'b1 && n < 40) begin
      gocnt++;
      n++;
      @(negedge clk);
    end
    chk("to_go_cycles", gocnt, 16);
    chk("to_err", b.oERR, 3'b010);
    chk("to_no_done", b.oDONE, 0);
    chk("to_rdata_kept", b.oRDATA, 8'hC3);
    @(negedge clk);
    chk("to_err_pulse", b.oERR, 0);
    chk("to_release", b.oGNT, 0);
    @(negedge clk);
    chk("to_next_gnt", b.oGNT, 3'b001);

    // End arriving on the very cycle the watchdog expires.
    repeat (15) @(negedge clk);
    b.iSPI_END  = 1'b1;
    b.iS2P_DATA = 8'h3C;
    @(negedge clk);
    chk("tie_done", b.oDONE, 3'b001);
    chk("tie_no_err", b.oERR, 0);
    chk("tie_rdata", b.oRDATA, 8'h3C);
    b.iSPI_END = 1'b0;
    b.iREQ     = 3'b000;
    @(negedge clk);
    chk("tie_release", b.oGNT, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Round-robin arbiter and sequencer that shares the single `spi_controller` transaction port between several on-chip requesters, such as the init writer, the INT_SOURCE poller and the axis-data reader. Each requester presents a 16-bit `{mode, register, data}` word. The arbiter grants the SPI engine to one requester at a time, drives `iSPI_GO`/`oSPI_END` handshake sequencing, and returns the read byte with a one-cycle done pulse. A lock input keeps the grant across back-to-back transactions, for example X_LB followed by X_HB. A watchdog aborts any transaction whose end never arrives.

## Interface
- `N_REQ`, 3: number of requesters (2..8).
- `CMD_W`, 16: command width, `{R/W, MB, addr[5:0], wdata[7:0]}`.
- `DATA_W`, 8: read-data width.
- `TIMEOUT`, 4096: maximum cycles in XFER before abort (≥4).

Ports:
- `iSPI_CLK` in 1: single clock for the block.
- `iRST` in 1: reset, synchronous and active-high.
- `iREQ` in N_REQ: request, level; bit i for requester i.
- `iREQ_LOCK` in N_REQ: hold the grant for the next transaction of the same requester.
- `iREQ_CMD` in N_REQ*CMD_W: packed commands; requester i at `[CMD_W*i +: CMD_W]`.
- `oGNT` out N_REQ: one-hot grant, all-zero when idle.
- `oDONE` out N_REQ: one-cycle pulse to the owner on normal completion.
- `oERR` out N_REQ: one-cycle pulse to the owner on timeout abort.
- `oRDATA` out DATA_W: byte captured from `iS2P_DATA`; valid while `oDONE` is high and held afterwards.
- `oBUSY` out 1: high in any state other than IDLE.
- `oP2S_DATA` out CMD_W: command to `spi_controller.iP2S_DATA`.
- `oSPI_GO` out 1: to `spi_controller.iSPI_GO`.
- `iSPI_END` in 1: from `spi_controller.oSPI_END`.
- `iS2P_DATA` in DATA_W: from `spi_controller.oS2P_DATA`.

## Operation
- All outputs are registered.
- States: IDLE, XFER, RELEASE.
- Round-robin pointer `ptr` (0..N_REQ-1):
  - Winner is the first i with `iREQ[i]=1`, searching `ptr, ptr+1, …` modulo N_REQ.
  - `ptr` becomes `owner+1` mod N_REQ each time the grant is released.
- **IDLE**: if any `iREQ` is set:
  - latch the winner as owner;
  - latch its command into `oP2S_DATA`;
  - set `oGNT[owner]=1` and `oSPI_GO=1`;
  - clear the watchdog; go to XFER.
  - Otherwise stay in IDLE with all outputs idle.
- **XFER**: `oSPI_GO` stays 1, and the watchdog increments each cycle.
  - If `iSPI_END=1`: `oSPI_GO←0`, `oDONE[owner]←1` for one cycle, `oRDATA←iS2P_DATA`; go to RELEASE.
  - Else if the watchdog reaches `TIMEOUT-1`: `oSPI_GO←0`, `oERR[owner]←1` for one cycle, `oRDATA` unchanged; go to RELEASE.
- **RELEASE**: wait for `iSPI_END=0`.
  - If `iREQ_LOCK[owner]` and `iREQ[owner]` are both 1: re-latch the owner's command, `oSPI_GO←1`, watchdog clear; go to XFER. `oGNT` stays and `ptr` does not move.
  - Otherwise: `oGNT←0`, update `ptr`, go to IDLE.
- The latched command is frozen for the whole transaction; changes to `iREQ_CMD` during XFER are ignored.
- Dropping `iREQ[owner]` mid-transaction does not abort it; done or err still pulses.
- `iREQ` from non-owners is ignored until IDLE.
- Simultaneous `iSPI_END` and watchdog expiry: end wins (done, no err).
- `iSPI_END` already high on entry to XFER: completes on that cycle. The controller guarantees end is low after GO drops, so this indicates a stale end; it is still treated as completion.

## Timing
- Reset values: state IDLE, `ptr=0`, and `oGNT`, `oDONE`, `oERR`, `oRDATA`, `oP2S_DATA`, `oSPI_GO`, `oBUSY` all 0.
- Reset mid-transaction: `oSPI_GO` is 0 after the first clock edge with `iRST=1`; no done or err is pulsed.
- Request latency: `iREQ` sampled high in IDLE at edge t → `oGNT`, `oP2S_DATA` and `oSPI_GO` valid after edge t.
- Completion latency: `iSPI_END` sampled high at edge e → `oDONE`/`oRDATA` valid and `oSPI_GO=0` after edge e.
- Release: `iSPI_END` sampled low in RELEASE at edge r → `oGNT` clears after edge r, or GO reasserts after edge r for a locked requester.
- Minimum idle gap between unlocked transactions: 1 cycle in IDLE.
- Timeout: abort occurs `TIMEOUT` cycles after GO rises.

## Test plan
- **Single request**: `iREQ=3'b001`, cmd `0x2D08`; model end after 20 cycles with `iS2P_DATA=0x5A` → `oGNT=001`, `oP2S_DATA=0x2D08`, GO high 20 cycles, `oDONE=001` for one cycle, `oRDATA=0x5A`, IDLE 2 cycles later.
- **Round-robin**: all three `iREQ` held high → grant order 0,1,2,0,1,2 for six transactions; never two consecutive grants to one requester.
- **Lock**: requester 1 locks while issuing `0xB200` then `0xB300` with `iREQ[0]` high → both of requester 1's transactions run back-to-back with no IDLE, then requester 2 is granted. Requester 2 is next because `ptr=2` after requester 1 releases, so requester 0 waits until after requester 2.
- **Timeout**: `TIMEOUT=16`, end never asserted → GO falls after 16 cycles, `oERR[owner]` pulses, `oRDATA` unchanged, next requester granted.
- **Boundary cases**:
  - end and timeout in the same cycle → `oDONE` pulses, `oERR` stays 0;
  - `iREQ_CMD` changed mid-XFER → `oP2S_DATA` unchanged;
  - `iRST` pulsed mid-XFER → all outputs 0 next cycle, `ptr=0`.
